// File: rtl/flexbex_ibex_data_mem_responder_if.sv
// Data-side memory bus between an Ibex-style load/store unit (master)
// and the memory responder (slave).
interface flexbex_ibex_data_mem_responder_if;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_err_o;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;

  modport master (
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o
  );

  modport slave (
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o
  );
endinterface

// File: rtl/flexbex_ibex_data_mem_responder.sv
// Single-outstanding data memory responder: programmable grant wait and
// response latency in front of a byte-writable word array.
module flexbex_ibex_data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int GNT_WAIT    = 0,
  parameter int RVALID_LAT  = 1
) (
  input logic                                  clk,
  input logic                                  rst_n,
  flexbex_ibex_data_mem_responder_if.slave     bus
);

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_MAX = 4'(GNT_WAIT);
  localparam logic [3:0] LAT_LAST = 4'(RVALID_LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, RESP_PEND} state_t;

  state_t      r_state;
  logic [3:0]  r_wait_cnt;
  logic [3:0]  r_lat_cnt;
  logic        r_rvalid;
  logic        r_resp_ld;
  logic        r_resp_oor;
  logic [31:0] r_rdata;

  logic [29:0]   w_idx;
  logic [AW-1:0] w_waddr;
  logic          w_in_range;
  logic          w_slot_free;
  logic          w_gnt;
  logic          w_wr_en;
  logic          w_rd_en;
  logic          w_deliver;
  logic [31:0]   w_mem_rd;
  logic          w_unused;

  assign w_idx      = bus.data_addr_i[31:2];
  assign w_waddr    = w_idx[AW-1:0];
  assign w_in_range = ({2'b00, w_idx} < 32'(DEPTH_WORDS));
  assign w_unused   = ^bus.data_addr_i[1:0];

  // The slot frees up in the rvalid cycle itself so a new request can overlap it.
  assign w_slot_free = (r_state != RESP_PEND) || r_rvalid;
  assign w_gnt       = rst_n && bus.data_req_i && (r_wait_cnt == WAIT_MAX) && w_slot_free;
  assign w_wr_en     = w_gnt && bus.data_we_i && w_in_range;
  assign w_rd_en     = w_gnt && !bus.data_we_i && w_in_range;

  assign w_deliver = (RVALID_LAT == 1) ? w_gnt
                   : ((r_state == RESP_PEND) && !r_rvalid && (r_lat_cnt == LAT_LAST));

  // One RAM per byte lane; the read register holds its word until the next read.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] r_mem [DEPTH_WORDS];
    logic [7:0] r_rd_byte;

    always_ff @(posedge clk) begin
      if (w_wr_en && bus.data_be_i[gi]) begin
        r_mem[w_waddr] <= bus.data_wdata_i[gi*8 +: 8];
      end
      if (w_rd_en) begin
        r_rd_byte <= r_mem[w_waddr];
      end
    end

    assign w_mem_rd[gi*8 +: 8] = r_rd_byte;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= 4'd0;
      r_lat_cnt  <= 4'd0;
      r_rvalid   <= 1'b0;
      r_resp_ld  <= 1'b0;
      r_resp_oor <= 1'b0;
      r_rdata    <= 32'h0000_0000;
    end else begin
      r_rvalid <= w_deliver;

      if (r_rvalid && r_resp_ld) begin
        r_rdata <= r_resp_oor ? 32'h0000_0000 : w_mem_rd;
      end

      if (w_gnt || !bus.data_req_i) begin
        r_wait_cnt <= 4'd0;
      end else if (r_wait_cnt != WAIT_MAX) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end

      if (w_gnt) begin
        r_state    <= RESP_PEND;
        r_lat_cnt  <= 4'd1;
        r_resp_ld  <= !bus.data_we_i || !w_in_range;
        r_resp_oor <= !w_in_range;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.data_req_i) r_state <= WAIT_GNT;
          end
          WAIT_GNT: begin
            if (!bus.data_req_i) r_state <= IDLE;
          end
          RESP_PEND: begin
            if (!r_rvalid) begin
              r_lat_cnt <= r_lat_cnt + 4'd1;
            end else begin
              r_state <= bus.data_req_i ? WAIT_GNT : IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Read-type responses present the RAM output register directly in the rvalid cycle.
  assign bus.data_gnt_o    = w_gnt;
  assign bus.data_rvalid_o = r_rvalid;
  assign bus.data_err_o    = r_rvalid && r_resp_oor;
  assign bus.data_rdata_o  = (r_rvalid && r_resp_ld) ? (r_resp_oor ? 32'h0000_0000 : w_mem_rd)
                                                     : r_rdata;

endmodule

// File: tb/tb_flexbex_ibex_data_mem_responder.sv
// Directed and randomized bench for two responder instances:
// A = (GNT_WAIT 0, RVALID_LAT 1), B = (GNT_WAIT 3, RVALID_LAT 4).
module tb_flexbex_ibex_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a;
  logic rst_n_b;

  flexbex_ibex_data_mem_responder_if bus_a();
  flexbex_ibex_data_mem_responder_if bus_b();

  flexbex_ibex_data_mem_responder #(.DEPTH_WORDS(1024), .GNT_WAIT(0), .RVALID_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .bus(bus_a)
  );
  flexbex_ibex_data_mem_responder #(.DEPTH_WORDS(1024), .GNT_WAIT(3), .RVALID_LAT(4)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(bus_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: word array per instance plus the last rdata value presented.
  logic [31:0] ref_mem [2][1024];
  logic [31:0] last_rd [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic req, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    if (w == 0) begin
      bus_a.data_req_i = req; bus_a.data_we_i = we; bus_a.data_addr_i = addr;
      bus_a.data_be_i = be; bus_a.data_wdata_i = wd;
    end else begin
      bus_b.data_req_i = req; bus_b.data_we_i = we; bus_b.data_addr_i = addr;
      bus_b.data_be_i = be; bus_b.data_wdata_i = wd;
    end
  endtask

  task automatic drive_idle(input int w);
    drive(w, 1'b0, 1'($urandom), $urandom, 4'($urandom), $urandom);
  endtask

  function automatic logic get_gnt(input int w);
    return (w == 0) ? bus_a.data_gnt_o : bus_b.data_gnt_o;
  endfunction
  function automatic logic get_rvalid(input int w);
    return (w == 0) ? bus_a.data_rvalid_o : bus_b.data_rvalid_o;
  endfunction
  function automatic logic get_err(input int w);
    return (w == 0) ? bus_a.data_err_o : bus_b.data_err_o;
  endfunction
  function automatic logic [31:0] get_rdata(input int w);
    return (w == 0) ? bus_a.data_rdata_o : bus_b.data_rdata_o;
  endfunction

  function automatic void model_apply(input int w, input logic we, input logic [31:0] addr,
                                      input logic [3:0] be, input logic [31:0] wd,
                                      output logic [31:0] exp_rd, output logic exp_err);
    int unsigned idx;
    idx = addr >> 2;
    if (idx >= 1024) begin
      exp_err = 1'b1;
      exp_rd  = 32'h0;
      last_rd[w] = 32'h0;
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[w][idx][b*8 +: 8] = wd[b*8 +: 8];
      exp_err = 1'b0;
      exp_rd  = last_rd[w];
    end else begin
      exp_err = 1'b0;
      exp_rd  = ref_mem[w][idx];
      last_rd[w] = exp_rd;
    end
  endfunction

  // Waits (bounded) for gnt; starts at posedge+1, returns at the negedge of the gnt cycle.
  task automatic wait_gnt(input int w, output int c);
    bit got = 0;
    c = 0;
    while (!got && c < 40) begin
      @(negedge clk); c++;
      if (get_gnt(w)) got = 1;
      else begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_rvalid(input int w, output int c);
    bit got = 0;
    c = 0;
    while (!got && c < 40) begin
      @(negedge clk); c++;
      if (get_rvalid(w)) got = 1;
      else begin @(posedge clk); #1; end
    end
  endtask

  task automatic txn(input int w, input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input string tag);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          c;
    int          gw  = (w == 0) ? 0 : 3;
    int          lat = (w == 0) ? 1 : 4;
    model_apply(w, we, addr, be, wd, exp_rd, exp_err);
    drive(w, 1'b1, we, addr, be, wd);
    wait_gnt(w, c);
    chk({tag, ".gnt_cycle"}, 32'(c), 32'(gw + 1));
    @(posedge clk); #1;
    drive_idle(w);
    wait_rvalid(w, c);
    chk({tag, ".rvalid_lat"}, 32'(c), 32'(lat));
    chk({tag, ".rdata"}, get_rdata(w), exp_rd);
    chk({tag, ".err"}, 32'(get_err(w)), 32'(exp_err));
    $display("txn %-10s dut%0d we=%0b addr=%h be=%b wd=%h -> rdata=%h err=%0b",
             tag, w, we, addr, be, wd, get_rdata(w), get_err(w));
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, ".rvalid_once"}, 32'(get_rvalid(w)), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic rand_txn(input int w);
    logic [31:0] addr;
    logic        we;
    if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h0000_1000;
    else addr = 32'($urandom_range(0, 15)) << 2;
    we = 1'($urandom);
    txn(w, we, addr, 4'($urandom), $urandom, "rnd");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e1, e2;
    logic        er;
    logic        s_we [4];
    logic [31:0] s_ad [4];
    logic [31:0] s_wd [4];
    logic [31:0] s_ex [4];
    int          c;
    int          seen;

    // Reset with req held high: gnt must stay low, outputs must clear.
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk("rst.gnt",    32'(get_gnt(w)),    32'd0);
      chk("rst.rvalid", 32'(get_rvalid(w)), 32'd0);
      chk("rst.err",    32'(get_err(w)),    32'd0);
      chk("rst.rdata",  get_rdata(w),       32'h0);
    end
    @(posedge clk); #1;
    drive_idle(0); drive_idle(1);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    @(posedge clk); #1;

    // Instance A: basic write/read, partial write, be=0000, out of range.
    txn(0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, "wr_full");
    txn(0, 1'b0, 32'h10, 4'b0000, 32'h0,        "rd_full");
    txn(0, 1'b1, 32'h10, 4'b0100, 32'h00AA0000, "wr_part");
    txn(0, 1'b0, 32'h13, 4'b0001, 32'h0,        "rd_part");
    txn(0, 1'b1, 32'h10, 4'b0000, 32'h12345678, "wr_be0");
    txn(0, 1'b0, 32'h10, 4'b1111, 32'h0,        "rd_be0");
    txn(0, 1'b1, 32'h00, 4'b1111, 32'hCAFEF00D, "wr_w0");
    txn(0, 1'b0, 32'h1000, 4'b1111, 32'h0,      "rd_oor");
    txn(0, 1'b1, 32'h1000, 4'b1111, 32'hBAADBAAD, "wr_oor");
    txn(0, 1'b0, 32'h00, 4'b1111, 32'h0,        "rd_alias");
    txn(0, 1'b1, 32'h14, 4'b1111, 32'h0BADC0DE, "wr_after");

    for (int i = 0; i < 16; i++) begin
      txn(0, 1'b1, 32'(i) << 2, 4'hF, $urandom, "init");
      txn(1, 1'b1, 32'(i) << 2, 4'hF, $urandom, "init");
    end

    // Instance A: one transaction per cycle with req held high.
    s_we[0] = 1'b0; s_ad[0] = 32'h04; s_wd[0] = 32'h0;
    s_we[1] = 1'b1; s_ad[1] = 32'h40; s_wd[1] = $urandom;
    s_we[2] = 1'b0; s_ad[2] = 32'h40; s_wd[2] = 32'h0;
    s_we[3] = 1'b0; s_ad[3] = 32'h08; s_wd[3] = 32'h0;
    drive(0, 1'b1, s_we[0], s_ad[0], 4'hF, s_wd[0]);
    model_apply(0, s_we[0], s_ad[0], 4'hF, s_wd[0], s_ex[0], er);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("b2b.gnt", 32'(get_gnt(0)), 32'd1);
      if (k > 0) begin
        chk("b2b.rvalid", 32'(get_rvalid(0)), 32'd1);
        chk("b2b.rdata",  get_rdata(0),       s_ex[k-1]);
      end
      @(posedge clk); #1;
      if (k < 3) begin
        drive(0, 1'b1, s_we[k+1], s_ad[k+1], 4'hF, s_wd[k+1]);
        model_apply(0, s_we[k+1], s_ad[k+1], 4'hF, s_wd[k+1], s_ex[k+1], er);
      end else begin
        drive_idle(0);
      end
    end
    @(negedge clk);
    chk("b2b.rvalid_last", 32'(get_rvalid(0)), 32'd1);
    chk("b2b.rdata_last",  get_rdata(0),       s_ex[3]);
    $display("txn b2b        dut0 4 beats, last rdata=%h", get_rdata(0));
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) rand_txn(0);

    // Instance B: second request held high while the first is pending.
    txn(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, "b_wr");
    model_apply(1, 1'b0, 32'h10, 4'hF, 32'h0, e1, er);
    drive(1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    wait_gnt(1, c);
    chk("pend.gnt_cycle", 32'(c), 32'd4);
    @(posedge clk); #1;
    model_apply(1, 1'b0, 32'h0C, 4'hF, 32'h0, e2, er);
    drive(1, 1'b1, 1'b0, 32'h0C, 4'hF, 32'h0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("pend.gnt_held", 32'(get_gnt(1)), 32'd0);
      chk("pend.rvalid_early", 32'(get_rvalid(1)), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("pend.gnt_overlap", 32'(get_gnt(1)), 32'd1);
    chk("pend.rvalid1", 32'(get_rvalid(1)), 32'd1);
    chk("pend.rdata1", get_rdata(1), e1);
    @(posedge clk); #1;
    drive_idle(1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("pend.rvalid2_early", 32'(get_rvalid(1)), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("pend.rvalid2", 32'(get_rvalid(1)), 32'd1);
    chk("pend.rdata2", get_rdata(1), e2);
    $display("txn pend       dut1 rdata1=%h rdata2=%h", e1, get_rdata(1));
    @(posedge clk); #1;

    // Instance B: req dropped before gnt yields nothing.
    drive(1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("drop.gnt", 32'(get_gnt(1)), 32'd0);
      @(posedge clk); #1;
    end
    drive_idle(1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (get_rvalid(1) || get_gnt(1)) seen++;
      @(posedge clk); #1;
    end
    chk("drop.no_activity", 32'(seen), 32'd0);
    $display("txn drop       dut1 req withdrawn before gnt");
    txn(1, 1'b0, 32'h10, 4'hF, 32'h0, "after_drop");

    // Instance B: reset in the cycle after gnt discards the response.
    drive(1, 1'b1, 1'b0, 32'h0C, 4'hF, 32'h0);
    wait_gnt(1, c);
    chk("mid_rst.gnt_cycle", 32'(c), 32'd4);
    @(posedge clk); #1;
    rst_n_b = 1'b0;
    @(negedge clk);
    chk("mid_rst.gnt_in_rst", 32'(get_gnt(1)), 32'd0);
    @(posedge clk); #1;
    rst_n_b = 1'b1;
    drive_idle(1);
    last_rd[1] = 32'h0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (get_rvalid(1)) seen++;
      @(posedge clk); #1;
    end
    chk("mid_rst.no_rvalid", 32'(seen), 32'd0);
    @(negedge clk);
    chk("mid_rst.rdata", get_rdata(1), 32'h0);
    @(posedge clk); #1;
    $display("txn mid_rst    dut1 pending response discarded");
    txn(1, 1'b0, 32'h10, 4'hF, 32'h0, "post_rst");

    for (int i = 0; i < 15; i++) rand_txn(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/flexbex_ibex_data_mem_responder.md
FLEXBEX_IBEX_DATA_MEM_RESPONDER -- requirements
Module: flexbex_ibex_data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words in the backing array.
REQ-002 SHALL have parameter GNT_WAIT, default 0, range 0..15: cycles of asserted req before gnt.
REQ-003 SHALL have parameter RVALID_LAT, default 1, range 1..8: cycles from gnt to rvalid.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-006 SHALL have port data_req_i  input  1: request from the initiator.
REQ-007 SHALL have port data_gnt_o  output  1: request accepted this cycle.
REQ-008 SHALL have port data_rvalid_o  output  1: response valid, one cycle per granted request.
REQ-009 SHALL have port data_err_o  output  1: error flag, qualified by rvalid.
REQ-010 SHALL have port data_addr_i  input  32: byte address; bits [1:0] are ignored.
REQ-011 SHALL have port data_we_i  input  1: 1 = write, 0 = read.
REQ-012 SHALL have port data_be_i  input  4: byte enables; bit n covers byte lane n.
REQ-013 SHALL have port data_wdata_i  input  32: write data, already lane-aligned.
REQ-014 SHALL have port data_rdata_o  output  32: read data, qualified by rvalid.

Function
REQ-015 SHALL implement a state machine with states IDLE, WAIT_GNT and RESP_PEND; at most one transaction outstanding at any time.
REQ-016 SHALL keep a wait counter that increments each cycle req is high and gnt is low, and clears on gnt or when req is low.
REQ-017 SHALL assert gnt combinationally when all hold: req=1; wait counter == GNT_WAIT; response slot free.
REQ-018 SHALL treat the response slot as free when no response is pending, or when the pending response asserts rvalid in the same cycle (back-to-back accept).
REQ-019 SHALL, with GNT_WAIT=0 and slot free, assert gnt in the same cycle req rises.
REQ-020 SHALL, when the slot is not free, hold gnt low and hold the wait counter at GNT_WAIT (saturating).
REQ-021 SHALL sample addr, we, be and wdata only in the gnt cycle; these inputs are don't-care on all other cycles.
REQ-022 SHALL define word index = addr[31:2]; an index >= DEPTH_WORDS is out of range.
REQ-023 SHALL, on an in-range write at gnt, update only the bytes with be=1 at the clock edge; be=0000 leaves the word unchanged but still produces a response.
REQ-024 SHALL, on an in-range read at gnt, capture the full 32-bit word (all lanes, independent of be) into the response register.
REQ-025 SHALL, on an out-of-range access, suppress the write, set the response rdata to 0 and set err=1 in the response.
REQ-026 SHALL assert rvalid for exactly one cycle, RVALID_LAT cycles after the gnt cycle, for reads and writes alike.
REQ-027 SHALL drive err=0 on every response except out-of-range accesses.
REQ-028 SHALL drive rdata with the captured word in the rvalid cycle of a read; rdata is unchanged on write responses and between responses.
REQ-029 SHALL, when a read is granted in the same cycle as a write to the same word, return the pre-write value to that read.
REQ-030 SHALL sustain one transaction per cycle when GNT_WAIT=0 and RVALID_LAT=1.
REQ-031 SHALL tolerate req dropping before gnt (protocol violation): return to IDLE, clear the wait counter, issue no response.

Reset
REQ-032 SHALL, when rst_n=0 at a clock edge, set: state IDLE; wait and latency counters 0; gnt, rvalid and err 0; rdata 0x00000000.
REQ-033 SHALL keep gnt low during any cycle with rst_n=0, even if req=1.
REQ-034 SHALL discard a response pending at reset: no rvalid follows reset release for it.
REQ-035 SHALL not reset the memory array; writes committed before reset persist.

Verification
REQ-036 SHALL cover, GNT_WAIT=0, RVALID_LAT=1: write 0xDEADBEEF be=1111 @0x10, then read @0x10 -> gnt on the req cycle, rvalid one cycle later, rdata=0xDEADBEEF, err=0.
REQ-037 SHALL cover a partial write: @0x10 holds 0xDEADBEEF; write wdata=0x00AA0000 be=0100 -> a following read returns 0xDEAABEEF.
REQ-038 SHALL cover GNT_WAIT=3: req held high -> gnt on the 4th cycle of req; rvalid RVALID_LAT cycles after gnt.
REQ-039 SHALL cover back-to-back: read @0x10, then req re-asserted in the rvalid cycle (misaligned-split pattern) -> second gnt in that same cycle; second rvalid on the next cycle.
REQ-040 SHALL cover out of range, DEPTH_WORDS=1024: read @0x00001000 -> rvalid=1, err=1, rdata=0; a write to that address leaves the array unchanged.
REQ-041 SHALL cover reset mid-operation: rst_n=0 in the cycle after gnt with RVALID_LAT=4 -> no rvalid after release; the next request completes normally.
